// File: rtl/mvp_fll_pkg.sv
// Shared constants and types for the FLL band/fine successive-approximation search.
package mvp_fll_pkg;

  localparam int CODE_W = 6;
  localparam int MEAS_W = 8;
  localparam int GAP_W  = 4;
  localparam int BIT_W  = $clog2(CODE_W);

  localparam logic [CODE_W-1:0] FINE_MID = CODE_W'(31);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_MEASURE,
    ST_SAMPLE,
    ST_GAP,
    ST_NEXT,
    ST_DONE
  } state_e;

  typedef enum logic {
    PH_BAND,
    PH_FINE
  } phase_e;

  typedef struct packed {
    logic too_fast;
    logic too_slow;
  } fll_stat_t;

  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/mvp_sar6_step.sv
// One 6-bit successive-approximation register, shared by the band and fine phases.
module mvp_sar6_step
  import mvp_fll_pkg::*;
(
  input  logic              refclk,
  input  logic              refclk_reset_n,
  input  logic              init,
  input  logic              step,
  input  fll_stat_t         stat,
  output logic [CODE_W-1:0] trial,
  output logic [CODE_W-1:0] acc_nxt,
  output logic              last,
  output logic              hit
);

  logic [CODE_W-1:0] acc;
  logic [BIT_W-1:0]  bit_idx;
  logic [CODE_W-1:0] bit_oh;

  assign bit_oh = CODE_W'(1) << bit_idx;
  assign trial  = acc | bit_oh;
  assign hit    = !stat.too_fast && !stat.too_slow;
  // Too slow or in range keeps the trial bit; too fast (incl. both flags) drops it.
  assign acc_nxt = stat.too_fast ? acc : trial;
  assign last    = hit || (bit_idx == '0);

  always_ff @(posedge refclk or negedge refclk_reset_n) begin
    if (!refclk_reset_n) begin
      acc     <= '0;
      bit_idx <= BIT_W'(CODE_W-1);
    end else if (init) begin
      acc     <= '0;
      bit_idx <= BIT_W'(CODE_W-1);
    end else if (step) begin
      acc <= acc_nxt;
      if (!last) bit_idx <= bit_idx - BIT_W'(1);
    end
  end

endmodule

// File: rtl/mvp_fll_search_ctrl.sv
// FLL VCO band/fine search: per trial apply code, enable FLL, sample fast/slow, idle, decide.
module mvp_fll_search_ctrl
  import mvp_fll_pkg::*;
(
  input  logic              refclk,
  input  logic              refclk_reset_n,
  input  logic              swi_search_en,
  input  logic              swi_search_fine,
  input  logic [MEAS_W-1:0] swi_meas_cycles,
  input  logic [GAP_W-1:0]  swi_gap_cycles,
  input  logic              fll_vco_too_fast,
  input  logic              fll_vco_too_slow,
  output logic              fll_enable,
  output logic              fll_manual_mode,
  output logic [CODE_W-1:0] fll_vco_band_start,
  output logic [CODE_W-1:0] fll_vco_fine_start,
  output logic              search_busy,
  output logic              search_done,
  output logic              search_in_range,
  output logic [CODE_W-1:0] band_result,
  output logic [CODE_W-1:0] fine_result
);

  state_e            state, state_nxt;
  phase_e            phase;
  logic [MEAS_W-1:0] cnt, cnt_nxt;
  logic              en_q;
  fll_stat_t         stat;
  logic              launch, sar_init, sar_step, band_wr, fine_wr, go_fine;
  logic [CODE_W-1:0] trial, acc_nxt;
  logic              last, hit;

  mvp_sar6_step u_sar (
    .refclk         (refclk),
    .refclk_reset_n (refclk_reset_n),
    .init           (sar_init),
    .step           (sar_step),
    .stat           (stat),
    .trial          (trial),
    .acc_nxt        (acc_nxt),
    .last           (last),
    .hit            (hit)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    sar_init  = 1'b0;
    sar_step  = 1'b0;
    band_wr   = 1'b0;
    fine_wr   = 1'b0;
    go_fine   = 1'b0;
    case (state)
      ST_IDLE: if (swi_search_en && !en_q) begin
        state_nxt = ST_APPLY;
        launch    = 1'b1;
        sar_init  = 1'b1;
      end
      ST_APPLY: begin
        state_nxt = ST_MEASURE;
        cnt_nxt   = swi_meas_cycles;
      end
      ST_MEASURE: begin
        if (cnt == '0) state_nxt = ST_SAMPLE;
        else           cnt_nxt   = cnt - MEAS_W'(1);
      end
      ST_SAMPLE: begin
        state_nxt = ST_GAP;
        cnt_nxt   = MEAS_W'(swi_gap_cycles);
      end
      ST_GAP: begin
        if (cnt == '0) state_nxt = ST_NEXT;
        else           cnt_nxt   = cnt - MEAS_W'(1);
      end
      ST_NEXT: begin
        sar_step = 1'b1;
        if (!last) begin
          state_nxt = ST_APPLY;
        end else if (phase == PH_BAND) begin
          band_wr = 1'b1;
          if (swi_search_fine) begin
            go_fine   = 1'b1;
            sar_init  = 1'b1;
            state_nxt = ST_APPLY;
          end else begin
            state_nxt = ST_DONE;
          end
        end else begin
          fine_wr   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (!swi_search_en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    // Abort wins over everything, including a phase end in the same cycle.
    if (is_busy(state) && !swi_search_en) begin
      state_nxt = ST_IDLE;
      sar_init  = 1'b0;
      sar_step  = 1'b0;
      band_wr   = 1'b0;
      fine_wr   = 1'b0;
      go_fine   = 1'b0;
    end
  end

  always_ff @(posedge refclk or negedge refclk_reset_n) begin
    if (!refclk_reset_n) begin
      state           <= ST_IDLE;
      phase           <= PH_BAND;
      cnt             <= '0;
      en_q            <= 1'b0;
      stat            <= '0;
      band_result     <= '0;
      fine_result     <= FINE_MID;
      search_in_range <= 1'b0;
      fll_enable      <= 1'b0;
      fll_manual_mode <= 1'b0;
      search_busy     <= 1'b0;
      search_done     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      en_q  <= swi_search_en;
      if (state == ST_SAMPLE) stat <= {fll_vco_too_fast, fll_vco_too_slow};
      if (launch) begin
        phase           <= PH_BAND;
        search_in_range <= 1'b0;
      end
      if (go_fine) phase <= PH_FINE;
      if (band_wr) begin
        band_result     <= acc_nxt;
        search_in_range <= hit;
      end
      if (fine_wr) begin
        fine_result     <= acc_nxt;
        search_in_range <= hit;
      end
      // Status and enable are registered from the next state so the FLL sees clean levels.
      fll_enable      <= (state_nxt == ST_MEASURE) || (state_nxt == ST_SAMPLE);
      fll_manual_mode <= is_busy(state_nxt);
      search_busy     <= is_busy(state_nxt);
      search_done     <= (state_nxt == ST_DONE);
    end
  end

  always_comb begin
    fll_vco_band_start = band_result;
    fll_vco_fine_start = fine_result;
    if (search_busy) begin
      if (phase == PH_BAND) begin
        fll_vco_band_start = trial;
        fll_vco_fine_start = FINE_MID;
      end else begin
        fll_vco_fine_start = trial;
      end
    end
  end

endmodule

// File: tb/tb_mvp_fll_search_ctrl.sv
// Scoreboard bench for mvp_fll_search_ctrl: stimulus queues expected trials/results, a monitor checks them.
module tb_mvp_fll_search_ctrl;

  typedef struct packed {
    logic [5:0] band;
    logic [5:0] fine;
    logic       in_range;
    logic       done;
  } res_t;

  logic       refclk = 1'b0;
  logic       refclk_reset_n = 1'b1;
  logic       swi_search_en = 1'b0;
  logic       swi_search_fine = 1'b0;
  logic [7:0] swi_meas_cycles = 8'd3;
  logic [3:0] swi_gap_cycles = 4'd2;
  logic       fll_vco_too_fast, fll_vco_too_slow;
  logic       fll_enable, fll_manual_mode;
  logic [5:0] fll_vco_band_start, fll_vco_fine_start;
  logic       search_busy, search_done, search_in_range;
  logic [5:0] band_result, fine_result;

  int n_chk = 0, n_fail = 0;
  int cur_meas = 3, cur_gap = 2;
  int band_t = 45, fine_t = 31, force_mode = 0;
  logic [11:0] trial_q[$];
  res_t        res_q[$];

  mvp_fll_search_ctrl dut (
    .refclk             (refclk),
    .refclk_reset_n     (refclk_reset_n),
    .swi_search_en      (swi_search_en),
    .swi_search_fine    (swi_search_fine),
    .swi_meas_cycles    (swi_meas_cycles),
    .swi_gap_cycles     (swi_gap_cycles),
    .fll_vco_too_fast   (fll_vco_too_fast),
    .fll_vco_too_slow   (fll_vco_too_slow),
    .fll_enable         (fll_enable),
    .fll_manual_mode    (fll_manual_mode),
    .fll_vco_band_start (fll_vco_band_start),
    .fll_vco_fine_start (fll_vco_fine_start),
    .search_busy        (search_busy),
    .search_done        (search_done),
    .search_in_range    (search_in_range),
    .band_result        (band_result),
    .fine_result        (fine_result)
  );

  always #5 refclk = ~refclk;

  // FLL model: band decides first; at the target band a mid fine code counts as in range.
  always @* begin
    fll_vco_too_fast = 1'b0;
    fll_vco_too_slow = 1'b0;
    if (force_mode == 1) fll_vco_too_fast = 1'b1;
    else if (force_mode == 2) fll_vco_too_slow = 1'b1;
    else if (int'(fll_vco_band_start) != band_t) begin
      fll_vco_too_fast = int'(fll_vco_band_start) > band_t;
      fll_vco_too_slow = int'(fll_vco_band_start) < band_t;
    end else if (fll_vco_fine_start != 6'd31) begin
      fll_vco_too_fast = int'(fll_vco_fine_start) > fine_t;
      fll_vco_too_slow = int'(fll_vco_fine_start) < fine_t;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic setup(input int bt, input int ft, input int fm, input int fe,
                       input int meas, input int gap);
    band_t = bt; fine_t = ft; force_mode = fm;
    swi_search_fine = fe[0];
    swi_meas_cycles = 8'(meas); swi_gap_cycles = 4'(gap);
    cur_meas = meas; cur_gap = gap;
  endtask

  task automatic tr(input int b, input int f);
    trial_q.push_back({6'(b), 6'(f)});
  endtask

  task automatic expect_res(input int b, input int f, input int ir, input int dn);
    res_t r;
    r.band = 6'(b); r.fine = 6'(f); r.in_range = ir[0]; r.done = dn[0];
    res_q.push_back(r);
  endtask

  task automatic run_to_done();
    int k;
    @(negedge refclk);
    swi_search_en = 1'b1;
    k = 0;
    while (k < 20000 && !search_done) begin
      @(negedge refclk);
      k++;
    end
    if (!search_done) begin
      n_chk++; n_fail++;
      $display("FAIL search_timeout: search_done=%0b expected 1", search_done);
    end
    swi_search_en = 1'b0;
    repeat (3) @(negedge refclk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_fll_enable"}, fll_enable, 0);
    chk({tag, "_manual_mode"}, fll_manual_mode, 0);
    chk({tag, "_band_start"}, fll_vco_band_start, 0);
    chk({tag, "_fine_start"}, fll_vco_fine_start, 31);
    chk({tag, "_busy"}, search_busy, 0);
    chk({tag, "_done"}, search_done, 0);
    chk({tag, "_in_range"}, search_in_range, 0);
    chk({tag, "_band_result"}, band_result, 0);
    chk({tag, "_fine_result"}, fine_result, 31);
  endtask

  // Monitor: trial codes and enable timing at each fll_enable edge, results when busy drops.
  initial begin
    logic pe, pb, seen;
    int hi, lo;
    logic [11:0] et;
    res_t r;
    pe = 1'b0; pb = 1'b0; seen = 1'b0; hi = 0; lo = 0;
    forever begin
      @(negedge refclk);
      if (fll_enable === 1'b1 && !pe) begin
        if (seen) chk("trial_enable_low_cycles", lo, cur_gap + 3);
        seen = 1'b1;
        hi = 0;
        chk("manual_mode_in_trial", fll_manual_mode, 1);
        if (trial_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_trial: band %0d fine %0d, none expected",
                   fll_vco_band_start, fll_vco_fine_start);
        end else begin
          et = trial_q.pop_front();
          chk("trial_band_code", fll_vco_band_start, et[11:6]);
          chk("trial_fine_code", fll_vco_fine_start, et[5:0]);
        end
      end
      if (fll_enable !== 1'b1 && pe && search_busy === 1'b1) begin
        chk("trial_enable_high_cycles", hi, cur_meas + 2);
        lo = 0;
      end
      if (search_busy !== 1'b1 && pb) begin
        if (res_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_search_end: band_result %0d", band_result);
        end else begin
          r = res_q.pop_front();
          chk("end_band_result", band_result, r.band);
          chk("end_fine_result", fine_result, r.fine);
          chk("end_in_range", search_in_range, r.in_range);
          chk("end_search_done", search_done, r.done);
          chk("end_fll_enable", fll_enable, 0);
          chk("end_manual_mode", fll_manual_mode, 0);
        end
      end
      if (search_busy !== 1'b1) seen = 1'b0;
      if (fll_enable === 1'b1) hi++; else lo++;
      pe = (fll_enable === 1'b1);
      pb = (search_busy === 1'b1);
    end
  end

  initial begin
    int k;
    logic p;
    int rises;
    #1 refclk_reset_n = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(negedge refclk);
    refclk_reset_n = 1'b1;
    @(negedge refclk);

    // Band-only, target 45
    setup(45, 31, 0, 0, 3, 2);
    tr(32, 31); tr(48, 31); tr(40, 31); tr(44, 31); tr(46, 31); tr(45, 31);
    expect_res(45, 31, 1, 1);
    run_to_done();

    // In range on the first trial
    setup(32, 31, 0, 0, 5, 1);
    tr(32, 31);
    expect_res(32, 31, 1, 1);
    run_to_done();

    // Always too fast, minimum timing
    setup(45, 31, 1, 0, 0, 0);
    tr(32, 31); tr(16, 31); tr(8, 31); tr(4, 31); tr(2, 31); tr(1, 31);
    expect_res(0, 31, 0, 1);
    run_to_done();

    // Always too slow, long timing
    setup(45, 31, 2, 0, 10, 15);
    tr(32, 31); tr(48, 31); tr(56, 31); tr(60, 31); tr(62, 31); tr(63, 31);
    expect_res(63, 31, 0, 1);
    run_to_done();

    // Abort during MEASURE of trial 3: results keep the previous search's values
    setup(45, 31, 0, 0, 6, 2);
    tr(32, 31); tr(48, 31); tr(40, 31);
    expect_res(63, 31, 0, 0);
    @(negedge refclk);
    swi_search_en = 1'b1;
    p = 1'b0; rises = 0; k = 0;
    while (k < 5000 && rises < 3) begin
      @(negedge refclk);
      if (fll_enable === 1'b1 && !p) rises++;
      p = (fll_enable === 1'b1);
      k++;
    end
    chk("abort_third_trial_seen", rises, 3);
    @(negedge refclk);
    swi_search_en = 1'b0;
    repeat (4) @(negedge refclk);

    // Band then fine search
    setup(20, 7, 0, 1, 3, 2);
    tr(32, 31); tr(16, 31); tr(24, 31); tr(20, 31);
    tr(20, 32); tr(20, 16); tr(20, 8); tr(20, 4); tr(20, 6); tr(20, 7);
    expect_res(20, 7, 1, 1);
    run_to_done();

    // Async reset in the middle of GAP after the first trial
    setup(45, 31, 0, 0, 2, 8);
    tr(32, 31);
    expect_res(0, 31, 0, 0);
    @(negedge refclk);
    swi_search_en = 1'b1;
    p = 1'b0; k = 0;
    while (k < 5000 && !(p && fll_enable !== 1'b1)) begin
      p = (fll_enable === 1'b1);
      @(negedge refclk);
      k++;
    end
    chk("reset_test_trial_end_seen", int'(p && fll_enable !== 1'b1), 1);
    @(posedge refclk);
    @(posedge refclk);
    #2 refclk_reset_n = 1'b0;
    #1 check_reset_values("async_reset");
    swi_search_en = 1'b0;
    repeat (3) @(negedge refclk);
    refclk_reset_n = 1'b1;
    repeat (3) @(negedge refclk);

    chk("trial_queue_drained", trial_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
